// File: rtl/sevenseg_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, waits for a stable one-hot digit, decodes the pattern back
// to its display code and hands it out on valid/ready. Define SEVENSEG_ACTIVE_LOW_EN for inverted inputs.
module sevenseg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_digit,
  output logic [4:0]            out_code,
  output logic                  out_dp,
  output logic                  out_err,
  output logic [5*DIGITS-1:0]   frame_codes,
  output logic                  overflow
);

  localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

  logic [7:0]        seg_in;
  logic [DIGITS-1:0] dig_in;

`ifdef SEVENSEG_ACTIVE_LOW_EN
  assign seg_in = ~seg;
  assign dig_in = ~dig_sel;
`else
  assign seg_in = seg;
  assign dig_in = dig_sel;
`endif

  logic [7:0]        seg_q;
  logic [DIGITS-1:0] dig_q;
  logic [7:0]        cnt;
  logic              armed;
  logic              same;
  logic              capture;
  logic [4:0]        dec_code;
  logic              dec_err;
  logic              dec_dp;
  logic [3:0]        dec_digit;

  assign same    = (seg_in == seg_q) && (dig_in == dig_q);
  assign capture = armed && (cnt == CAP_CNT) && $onehot(dig_q);

  always_comb begin
    dec_code = 5'd31;
    case (seg_q[6:0])
      7'h3F: dec_code = 5'd0;
      7'h06: dec_code = 5'd1;
      7'h5B: dec_code = 5'd2;
      7'h4F: dec_code = 5'd3;
      7'h66: dec_code = 5'd4;
      7'h6D: dec_code = 5'd5;
      7'h7D: dec_code = 5'd6;
      7'h07: dec_code = 5'd7;
      7'h7F: dec_code = 5'd8;
      7'h6F: dec_code = 5'd9;
      7'h77: dec_code = 5'd10;
      7'h7C: dec_code = 5'd11;
      7'h39: dec_code = 5'd12;
      7'h5E: dec_code = 5'd13;
      7'h79: dec_code = 5'd14;
      7'h71: dec_code = 5'd15;
      7'h40: dec_code = 5'd17;
      7'h08: dec_code = 5'd18;
      7'h00: dec_code = 5'd20;
      default: dec_code = 5'd31;
    endcase
    dec_err = (dec_code == 5'd31);
    // A blank digit never shows a decimal point.
    dec_dp  = (dec_code == 5'd20) ? 1'b0 : seg_q[7];
  end

  always_comb begin
    dec_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[i]) dec_digit = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q       <= '0;
      dig_q       <= '0;
      cnt         <= '0;
      armed       <= 1'b1;
      out_valid   <= 1'b0;
      out_digit   <= '0;
      out_code    <= '0;
      out_dp      <= 1'b0;
      out_err     <= 1'b0;
      overflow    <= 1'b0;
      frame_codes <= {DIGITS{5'd20}};
    end else begin
      seg_q <= seg_in;
      dig_q <= dig_in;

      if (!same)              cnt <= '0;
      else if (cnt != 8'hFF)  cnt <= cnt + 8'd1;

      if (!same)              armed <= 1'b1;
      else if (capture)       armed <= 1'b0;

      for (int i = 0; i < DIGITS; i++) begin
        if (capture && dig_q[i]) frame_codes[5*i +: 5] <= dec_code;
      end

      if (capture && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_digit <= dec_digit;
        out_code  <= dec_code;
        out_dp    <= dec_dp;
        out_err   <= dec_err;
      end else if (capture) begin
        overflow  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus random scanning, all checked
// every cycle against a window-based reference model.
module tb_sevenseg_scan_decoder;
  localparam int DIGITS = 4;
  localparam int S      = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_digit;
  logic [4:0]          out_code;
  logic                out_dp;
  logic                out_err;
  logic [5*DIGITS-1:0] frame_codes;
  logic                overflow;

  always #5 clk = ~clk;

  sevenseg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dig_sel(dig_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_code(out_code), .out_dp(out_dp), .out_err(out_err),
    .frame_codes(frame_codes), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] pat_tab [19] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                               7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h08, 7'h00};
  logic [4:0] code_tab [19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd20};

  function automatic logic [4:0] ref_code(input logic [6:0] p);
    for (int i = 0; i < 19; i++) begin
      if (pat_tab[i] == p) return code_tab[i];
    end
    return 5'd31;
  endfunction

  // Model: a window is the run of edges over which the sampled value stays the same;
  // a window with a one-hot digit yields exactly one capture, S edges after it opened.
  int          n = 0;
  int          m_start = 0;
  int          acc = 0;
  logic        seen_valid = 1'b0;
  logic [11:0] m_val;
  logic        m_valid, m_dp, m_err, m_ovf;
  logic [3:0]  m_digit;
  logic [4:0]  m_code;
  logic [4:0]  m_frame [DIGITS];

  task automatic model_edge();
    n++;
    if (reset) begin
      m_val = '0; m_start = n;
      m_valid = 1'b0; m_digit = '0; m_code = '0; m_dp = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
      for (int i = 0; i < DIGITS; i++) m_frame[i] = 5'd20;
      return;
    end
    if ((n - m_start == S) && $onehot(m_val[DIGITS-1:0])) begin
      logic [4:0] c;
      int d;
      c = ref_code(m_val[10:4]);
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (m_val[i]) d = i;
      m_frame[d] = c;
      if (m_valid && !out_ready) begin
        m_ovf = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_digit = 4'(d);
        m_code  = c;
        m_err   = (c == 5'd31);
        m_dp    = (c == 5'd20) ? 1'b0 : m_val[11];
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if ({seg, dig_sel} != m_val) begin
      m_val   = {seg, dig_sel};
      m_start = n;
    end
  endtask

  task automatic compare();
    logic [5*DIGITS-1:0] f;
    for (int i = 0; i < DIGITS; i++) f[5*i +: 5] = m_frame[i];
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("out_digit",   32'(out_digit),   32'(m_digit));
    chk("out_code",    32'(out_code),    32'(m_code));
    chk("out_dp",      32'(out_dp),      32'(m_dp));
    chk("out_err",     32'(out_err),     32'(m_err));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("frame_codes", 32'(frame_codes), 32'(f));
  endtask

  task automatic step();
    if (out_valid && out_ready) acc++;
    @(posedge clk);
    model_edge();
    #1;
    if (out_valid) seen_valid = 1'b1;
    compare();
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int cycles);
    seg = s;
    dig_sel = d;
    repeat (cycles) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int i = 1; i <= limit && at < 0; i++) begin
      step();
      if (out_valid) at = i;
    end
  endtask

  initial begin
    int at;
    reset = 1'b1; seg = 8'h00; dig_sel = '0; out_ready = 1'b1;

    // Single digit: latency and one accepted pulse
    seg = 8'h06; dig_sel = 4'b0001;
    do_reset();
    acc = 0;
    wait_valid(40, at);
    chk("lat_first", 32'(at), 32'd17);
    hold(8'h06, 4'b0001, 12);
    chk("single_acc", 32'(acc), 32'd1);
    chk("frame_d0", 32'(frame_codes[4:0]), 32'd1);

    // Hex scan 0..F with dp on digit 2
    acc = 0;
    for (int c = 0; c < 16; c++) hold({1'b1, pat_tab[c]}, 4'b0100, 20);
    chk("scan_acc", 32'(acc), 32'd16);
    chk("scan_code", 32'(out_code), 32'd15);
    chk("scan_dp", 32'(out_dp), 32'd1);
    chk("scan_digit", 32'(out_digit), 32'd2);

    // Aliases and an unrecognised pattern
    acc = 0;
    hold(8'hFF, 4'b0001, 20);
    hold(8'h6D, 4'b0001, 20);
    hold(8'h2A, 4'b0001, 20);
    chk("alias_acc", 32'(acc), 32'd3);
    chk("err_code", 32'(out_code), 32'd31);
    chk("err_flag", 32'(out_err), 32'd1);

    // Consumer stalled: second capture is dropped
    out_ready = 1'b0;
    do_reset();
    hold(8'h5B, 4'b0010, 20);
    hold(8'h4F, 4'b1000, 20);
    chk("stall_code", 32'(out_code), 32'd2);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_ovf", 32'(overflow), 32'd1);
    chk("stall_frame3", 32'(frame_codes[19:15]), 32'd3);

    // Reset in the middle of a window
    out_ready = 1'b1;
    hold(8'h06, 4'b0001, 12);
    reset = 1'b1;
    step();
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_frame", 32'(frame_codes), 32'(20'ha5294));
    reset = 1'b0;
    wait_valid(40, at);
    chk("rst_lat", 32'(at), 32'd17);

    // Glitch and multi-hot windows never capture
    do_reset();
    seen_valid = 1'b0;
    hold(8'h06, 4'b0001, 10);
    hold(8'h5B, 4'b0001, 10);
    hold(8'h5B, 4'b0011, 20);
    chk("glitch_none", 32'(seen_valid), 32'd0);

    // Random scanning with random backpressure and occasional reset
    for (int k = 0; k < 250; k++) begin
      int len;
      int r;
      len = $urandom_range(1, 24);
      r = $urandom_range(0, 9);
      if (r < 6) seg = {1'($urandom_range(0, 1)), pat_tab[$urandom_range(0, 18)]};
      else       seg = 8'($urandom);
      dig_sel = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      for (int j = 0; j < len; j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 199) == 0);
        step();
      end
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_decoder.md
# sevenseg_scan_decoder

Snooping decoder for multiplexed common-cathode 7-segment display lines.
- Samples the segment bus and digit-enable lines driven toward the Pmod display.
- Waits for each digit's pattern to be stable, then maps the segment pattern back to the 5-bit display code used by our hex-digit encoder.
- Hands each decoded digit out over a valid/ready interface.
- Sits in loopback self-test and on-board debug paths, where the display outputs are checked against the values the design intended to show.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1..9); width of dig_sel.
- STABLE_CYCLES, 16, consecutive identical samples required before capture (2..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seg  in  8  segment lines {dp,g,f,e,d,c,b,a}; 1 = segment lit.
- dig_sel  in  DIGITS  digit enables; 1 = digit driven.
- out_valid  out  1  decoded digit available.
- out_ready  in  1  consumer accepts the digit when out_valid && out_ready.
- out_digit  out  4  index of the decoded digit (bit position in dig_sel).
- out_code  out  5  decoded display code.
- out_dp  out  1  decimal-point state of the decoded digit.
- out_err  out  1  segment pattern not recognised; out_code = 5'd31.
- frame_codes  out  5*DIGITS  last decoded code per digit; digit i occupies bits [5i+4:5i].
- overflow  out  1  sticky: a capture was dropped because out_valid was pending.

## Operation
- Sample register s_q holds {seg, dig_sel}, reloaded every cycle.
- Stability counter cnt:
  - Increments (saturating at 255) when the current inputs equal s_q.
  - Cleared to 0 when they differ.
  - Any input change re-arms capture.
- Capture fires when cnt == STABLE_CYCLES-1, armed = 1, and s_q.dig_sel is exactly one-hot.
  - On capture, armed clears; at most one capture per stable window.
  - dig_sel zero or multi-hot never captures, but cnt still counts.
- Decoding uses seg[6:0] (gfedcba) only; seg[7] passes to out_dp:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F.
  - 0x40→17 (minus), 0x08→18 (underscore), 0x00→20 (blank).
  - Any other pattern → code 31 with out_err = 1.
- Alias rules:
  - Codes 16 and 19 are never emitted. All-on decodes as 8 with dp = 1; "S" decodes as 5.
  - Code 20 (blank) forces out_dp = 0 regardless of seg[7].
- Output handshake, single holding register:
  - Capture with out_valid = 0 loads the register; out_valid rises.
  - Capture with out_valid = 1 and out_ready = 1 in the same cycle loads the new digit; out_valid stays 1.
  - Capture with out_valid = 1 and out_ready = 0 drops the new digit and sets overflow.
  - out_valid && out_ready with no capture clears out_valid.
- frame_codes[digit] updates on every capture, including dropped ones.
- Reset values:
  - out_valid 0, out_digit 0, out_code 0, out_dp 0, out_err 0, overflow 0.
  - frame_codes all 5'd20 (blank), cnt 0, armed 1, s_q 0.
- Reset asserted mid-window discards the pending capture and the held output. Counting restarts from the first sample after reset deassertion.

## Timing
- Edge E0 is the first edge at which a new input value is sampled (cnt → 0).
- With inputs held stable, cnt reaches STABLE_CYCLES-1 at E(STABLE_CYCLES-1). out_valid and out_* are registered high after E(STABLE_CYCLES).
- Capture latency from first sampled change: STABLE_CYCLES edges.
- A change at any edge before E(STABLE_CYCLES-1) cancels the capture.
- Throughput: one capture per STABLE_CYCLES cycles per stable window; the consumer may hold out_ready low indefinitely.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- SEVENSEG_ACTIVE_LOW_EN: when defined, seg and dig_sel are inverted at the input, before s_q, for common-anode / low-side-driven displays. All other behaviour is identical.
- When undefined, inputs are active-high as listed above.

## Test plan
- Reset, then hold seg = 8'h06, dig_sel = 4'b0001, STABLE_CYCLES = 16, out_ready = 1 → one out_valid pulse after E16 with out_digit 0, out_code 1, out_dp 0, out_err 0; frame_codes[4:0] = 1.
- Scan codes 0..F with dp = 1 on digit 2, each held 20 cycles, out_ready = 1 → 16 captures, out_code 0..15, out_dp = 1, all 16 with out_digit 2.
- seg = 8'hFF, then 8'h6D, then 8'h2A → codes 8 (dp = 1), 5 (dp = 0), 31 with out_err = 1.
- out_ready = 0 and two digits captured in sequence (0x5B on digit 1, then 0x4F on digit 3) → out_code stays 2, overflow = 1, frame_codes digit 3 = 3.
- Glitch: seg changes at cycle 10 of a 16-cycle window, and dig_sel = 4'b0011 for a full window → no capture in either case; out_valid stays 0.
- Assert reset at cycle 12 of a window, then hold the inputs → no output until 16 edges after reset deassertion; overflow, out_valid and frame_codes return to their reset values.
